// File: rtl/cross_entropy_grad_stage.sv
// Two-stage valid/ready pipeline producing the cross-entropy gradient dL/dp
// from a Q12 sigmoid output and a binary label, plus batch-length tracking.

module cross_entropy_table_1 #(
    parameter int IDX_W = 12,
    parameter int OUT_W = 13
) (
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] t
);
    logic [OUT_W-1:0] den;

    // T(idx) = 4096 / (4096 - idx); idx <= 4095 keeps den >= 1
    always_comb begin
        den = OUT_W'(4096) - OUT_W'(idx);
        t   = OUT_W'(4096) / den;
    end
endmodule

module cross_entropy_grad_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 10,
    parameter int P_MAX  = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_p,
    input  logic              in_label,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_grad,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_err,
    output logic              clamp_err,
    output logic [CNT_W-1:0]  batch_len,
    output logic              batch_done
);
    localparam int IDX_W = $clog2(P_MAX + 1);
    localparam int T_W   = IDX_W + 1;

    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_label;
    logic             s1_last;

    logic             adv;
    logic             in_acc;
    logic             out_hs;
    logic [IDX_W-1:0] p_c;
    logic             clamp_hit;
    logic [T_W-1:0]   idx_w;
    logic [IDX_W-1:0] idx_n;
    logic [T_W-1:0]   t_val;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign in_acc   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        p_c       = in_p[IDX_W-1:0];
        clamp_hit = 1'b0;
        if ($signed(in_p) < 0) begin
            p_c       = '0;
            clamp_hit = 1'b1;
        end else if ($signed(in_p) > P_MAX) begin
            p_c       = IDX_W'(P_MAX);
            clamp_hit = 1'b1;
        end
        // label 1 reuses the same table through 1/p = T(4096 - p)
        idx_w = in_label ? (T_W'(4096) - {1'b0, p_c}) : {1'b0, p_c};
        idx_n = (idx_w > T_W'(P_MAX)) ? IDX_W'(P_MAX) : idx_w[IDX_W-1:0];
    end

    cross_entropy_table_1 #(
        .IDX_W(IDX_W),
        .OUT_W(T_W)
    ) u_table (
        .idx(s1_idx),
        .t  (t_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_label <= 1'b0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_idx   <= idx_n;
                s1_label <= in_label;
                s1_last  <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_grad  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_grad <= s1_label ? -DATA_W'(t_val) : DATA_W'(t_val);
                out_last <= s1_last;
            end
        end
    end

    // a clamp in the same cycle as clr_err must leave the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_err <= 1'b0;
        end else if (in_acc && clamp_hit) begin
            clamp_err <= 1'b1;
        end else if (clr_err) begin
            clamp_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            batch_len  <= '0;
            batch_done <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            if (out_hs) begin
                if (out_last) begin
                    batch_len  <= cnt_inc;
                    cnt        <= '0;
                    batch_done <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_cross_entropy_grad_stage.sv
// Scoreboard bench for cross_entropy_grad_stage: expected gradients are queued
// on input accept and compared on each output handshake.

module tb_cross_entropy_grad_stage;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 10;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_p;
    logic              in_label;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_grad;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              clr_err;
    logic              clamp_err;
    logic [CNT_W-1:0]  batch_len;
    logic              batch_done;

    int n_checks;
    int n_pass;

    int qg[$];
    bit ql[$];
    int occ;
    int m_cnt;
    int exp_len;
    bit pend_done;
    bit prev_stall;
    int prev_grad;
    bit prev_last;

    cross_entropy_grad_stage #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .P_MAX (4095)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_p      (in_p),
        .in_label  (in_label),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_grad  (out_grad),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .clamp_err (clamp_err),
        .batch_len (batch_len),
        .batch_done(batch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_grad(input int p, input bit lab);
        int pc;
        pc = (p < 0) ? 0 : (p > 4095) ? 4095 : p;
        if (!lab) return 4096 / (4096 - pc);
        if (pc == 0) return -4096;
        return -(4096 / pc);
    endfunction

    // scoreboard / protocol monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            qg.delete();
            ql.delete();
            occ        = 0;
            m_cnt      = 0;
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("batch_done", int'(batch_done), int'(pend_done));
            if (pend_done) chk("batch_len", int'(batch_len), exp_len);
            pend_done = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_grad", int'($signed(out_grad)), prev_grad);
                chk("hold_last", int'(out_last), int'(prev_last));
            end
            chk("in_ready", int'(in_ready), int'(!(occ == 2 && !out_ready)));
            if (in_valid && in_ready) begin
                qg.push_back(exp_grad(int'($signed(in_p)), in_label));
                ql.push_back(in_last);
                occ++;
            end
            if (out_valid && out_ready) begin
                if (qg.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("out_grad", int'($signed(out_grad)), qg.pop_front());
                    chk("out_last", int'(out_last), int'(ql.pop_front()));
                end
                occ--;
                if (out_last) begin
                    exp_len   = (m_cnt >= 1023) ? 1023 : m_cnt + 1;
                    m_cnt     = 0;
                    pend_done = 1'b1;
                end else if (m_cnt < 1023) begin
                    m_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_grad  = int'($signed(out_grad));
            prev_last  = out_last;
        end
    end

    task automatic send(input int p, input bit lab, input bit last);
        bit acc;
        in_p     = DATA_W'(p);
        in_label = lab;
        in_last  = last;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && qg.size() != 0; i++) @(posedge clk);
        chk("drain_left", qg.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_p      = '0;
        in_label  = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_grad", int'(out_grad), 0);
        chk("rst_clamp_err", int'(clamp_err), 0);
        chk("rst_batch_len", int'(batch_len), 0);
        chk("rst_batch_done", int'(batch_done), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // batch of 5, then a batch of 3 counting from zero
        for (int i = 0; i < 5; i++) send(100 * (i + 1), i[0], i == 4);
        idle();
        drain();
        chk("batch1_len", int'(batch_len), 5);
        for (int i = 0; i < 3; i++) send(3000 + i, 1'b0, i == 2);
        idle();
        drain();
        chk("batch2_len", int'(batch_len), 3);

        // latency: result visible one edge after the accepting edge
        send(2048, 1'b0, 1'b0);
        idle();
        chk("lat_early", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_grad", int'($signed(out_grad)), 2);
        drain();

        send(2048, 1'b1, 1'b0);
        send(4095, 1'b0, 1'b0);
        send(4, 1'b1, 1'b0);
        send(0, 1'b1, 1'b0);
        idle();
        chk("p0_no_clamp", int'(clamp_err), 0);
        drain();

        send(-5, 1'b0, 1'b0);
        idle();
        chk("clamp_neg", int'(clamp_err), 1);
        send(5000, 1'b0, 1'b0);
        idle();
        chk("clamp_high", int'(clamp_err), 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clamp_clear", int'(clamp_err), 0);
        clr_err = 1'b1;
        send(-1, 1'b1, 1'b0);
        clr_err = 1'b0;
        idle();
        chk("clamp_set_wins", int'(clamp_err), 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clamp_clear2", int'(clamp_err), 0);
        drain();

        // 8-sample stream under a 1-on/2-off out_ready pattern
        fork
            begin
                for (int i = 0; i < 8; i++) send(int'($urandom_range(1, 4095)), 1'($urandom_range(0, 1)), 1'b0);
                idle();
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = (k % 3 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // reset with two samples in flight
        out_ready = 1'b0;
        send(1000, 1'b0, 1'b0);
        send(1024, 1'b1, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_batch_len", int'(batch_len), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(1024, 1'b1, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_grad", int'($signed(out_grad)), -4);
        drain();
        chk("post_rst_len", int'(batch_len), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
